// File: rtl/checker_hm_pkg.sv
// Shared types, constants and data-pattern helpers for the checker_hm_stub page-read model.
package checker_hm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2,
    ST_TOUT = 2'd3
  } hm_state_e;

  localparam int unsigned WORD_BYTES   = 32'd8;
  localparam int unsigned PAGE_BYTES   = 32'd4096;
  localparam logic [63:0] DEFAULT_SEED = 64'h1234_5678_8765_4321;

  function automatic logic [63:0] hm_word(input logic [51:0] page,
                                          input logic [11:0] off,
                                          input logic [63:0] seed);
    return {page, off} ^ seed;
  endfunction

  // The offset wraps inside the page; the page address itself never advances.
  function automatic logic [11:0] hm_next_off(input logic [11:0] off);
    return 12'((32'(off) + WORD_BYTES) % PAGE_BYTES);
  endfunction

endpackage

// File: rtl/checker_hm_timer.sv
// 8-bit loadable down-counter with enable-gated decrement; expired_o is high at zero.
module checker_hm_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       expired_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: load wins over decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 8'd0);

endmodule

// File: rtl/checker_hm_stub.sv
// Host-memory page read stub: latency-delayed bursts of seeded data, or a timeout for unmapped pages.
// Define CHECKER_HM_ERRINJ_EN to add the hm_inject port that forces the timeout path at accept.
module checker_hm_stub
  import checker_hm_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LATENCY    = 8,
  parameter int unsigned TO_CYCLES  = 16,
  parameter logic [63:0] PAGE_LIMIT = 64'h0000_0001_0000_0000,
  parameter logic [63:0] SEED       = DEFAULT_SEED
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic              hm_start,
  input  logic [63:0]       hm_page_addr,
  input  logic [11:0]       hm_page_offset,
  input  logic [3:0]        hm_len,
`ifdef CHECKER_HM_ERRINJ_EN
  input  logic              hm_inject,
`endif
  output logic [DATA_W-1:0] hm_data,
  output logic              hm_valid,
  output logic              hm_end,
  output logic              hm_timeout,
  output logic              hm_busy
);

  hm_state_e          state_q, state_d;
  logic [51:0]        addr_q, addr_d;
  logic [11:0]        off_q, off_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         idx_q, idx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               end_q, end_d;
  logic               tout_q, tout_d;

  logic               load_s;
  logic [7:0]         load_val_s;
  logic               dec_s;
  logic               expired_s;
  logic               fail_s;
  logic               emit_s;
  logic [63:0]        word_s;

`ifdef CHECKER_HM_ERRINJ_EN
  assign fail_s = (hm_page_addr >= PAGE_LIMIT) || hm_inject;
`else
  assign fail_s = (hm_page_addr >= PAGE_LIMIT);
`endif

  assign word_s = hm_word(addr_q, off_q, SEED);

  checker_hm_timer u_timer (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .dec_i      (dec_s),
    .expired_o  (expired_s)
  );

  // Next-state, request latch and pulse generation; all pulses default low.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    len_d      = len_q;
    idx_d      = idx_q;
    data_d     = '0;
    valid_d    = 1'b0;
    end_d      = 1'b0;
    tout_d     = 1'b0;
    load_s     = 1'b0;
    load_val_s = 8'd0;
    dec_s      = 1'b0;
    emit_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start seen while the end/timeout pulse is still out is dropped.
        if (en && hm_start && !end_q && !tout_q) begin
          addr_d = hm_page_addr[51:0];
          off_d  = hm_page_offset;
          len_d  = hm_len;
          idx_d  = 4'd0;
          load_s = 1'b1;
          if (fail_s) begin
            state_d    = ST_TOUT;
            load_val_s = 8'(TO_CYCLES - 1);
          end else begin
            state_d    = ST_WAIT;
            load_val_s = 8'(LATENCY);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (en && expired_s) begin
          emit_s = 1'b1;
        end else begin
          dec_s = en;
        end
      end
      ST_DATA: begin
        emit_s = en;
      end
      ST_TOUT: begin
        if (en && expired_s) begin
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          dec_s = en;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (emit_s) begin
      valid_d = 1'b1;
      data_d  = word_s[DATA_W-1:0];
      off_d   = hm_next_off(off_q);
      idx_d   = idx_q + 4'd1;
      if (idx_q == len_q) begin
        end_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_DATA;
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 52'd0;
      off_q   <= 12'd0;
      len_q   <= 4'd0;
      idx_q   <= 4'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      tout_q  <= tout_d;
    end
  end

  assign hm_data    = data_q;
  assign hm_valid   = valid_q;
  assign hm_end     = end_q;
  assign hm_timeout = tout_q;
  assign hm_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_checker_hm_stub.sv
// Directed, table-driven bench for checker_hm_stub at default parameters.
module tb_checker_hm_stub;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic        hm_start;
  logic [63:0] hm_page_addr;
  logic [11:0] hm_page_offset;
  logic [3:0]  hm_len;
`ifdef CHECKER_HM_ERRINJ_EN
  logic        hm_inject;
`endif
  logic [63:0] hm_data;
  logic        hm_valid;
  logic        hm_end;
  logic        hm_timeout;
  logic        hm_busy;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  checker_hm_stub dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .en             (en),
    .hm_start       (hm_start),
    .hm_page_addr   (hm_page_addr),
    .hm_page_offset (hm_page_offset),
    .hm_len         (hm_len),
`ifdef CHECKER_HM_ERRINJ_EN
    .hm_inject      (hm_inject),
`endif
    .hm_data        (hm_data),
    .hm_valid       (hm_valid),
    .hm_end         (hm_end),
    .hm_timeout     (hm_timeout),
    .hm_busy        (hm_busy)
  );

  typedef struct {
    logic [63:0] addr;
    logic [11:0] off;
    logic [3:0]  len;
    logic        tout;
    int          lat;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] w2;
    logic [63:0] w3;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [63:0] addr, input logic [11:0] off,
                              input logic [3:0] len, input logic tout, input int lat,
                              input logic [63:0] w0, input logic [63:0] w1,
                              input logic [63:0] w2, input logic [63:0] w3);
    vec_t v;
    v.addr = addr; v.off = off; v.len = len; v.tout = tout; v.lat = lat;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
    return v;
  endfunction

  function automatic logic [63:0] word_of(input vec_t v, input int i);
    case (i)
      0:       return v.w0;
      1:       return v.w1;
      2:       return v.w2;
      default: return v.w3;
    endcase
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input vec_t v);
    hm_page_addr   = v.addr;
    hm_page_offset = v.off;
    hm_len         = v.len;
    hm_start       = 1'b1;
    step();
    hm_start       = 1'b0;
  endtask

  // Waits for the first valid/timeout pulse after an accept; returns cycles taken.
  task automatic wait_pulse(input string tag, input int limit, output int cyc);
    int  bad;
    bit  found;
    bad   = 0;
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < limit) begin
      hm_start     = (cyc < 4) ? 1'b1 : 1'b0;
      hm_page_addr = 64'h0000_0000_0000_DEAD;
      step();
      cyc++;
      if (hm_valid || hm_timeout) begin
        found = 1'b1;
      end else if (hm_busy !== 1'b1 || hm_end !== 1'b0 || hm_data !== 64'd0) begin
        bad++;
      end
    end
    hm_start = 1'b0;
    check($sformatf("%s_quiet_wait", tag), 64'(bad), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    accept(v);
    wait_pulse(tag, 40, cyc);
    check($sformatf("%s_latency", tag), 64'(cyc), 64'(v.lat));
    if (v.tout) begin
      check($sformatf("%s_timeout", tag), {63'd0, hm_timeout}, 64'd1);
      check($sformatf("%s_no_valid", tag), {62'd0, hm_valid, hm_end}, 64'd0);
      step();
      check($sformatf("%s_after", tag), {61'd0, hm_busy, hm_timeout, hm_valid}, 64'd0);
    end else begin
      for (int w = 0; w <= int'(v.len); w++) begin
        if (w > 0) step();
        check($sformatf("%s_valid%0d", tag, w), {63'd0, hm_valid}, 64'd1);
        check($sformatf("%s_data%0d", tag, w), hm_data, word_of(v, w));
        check($sformatf("%s_end%0d", tag, w), {63'd0, hm_end}, (w == int'(v.len)) ? 64'd1 : 64'd0);
      end
      step();
      check($sformatf("%s_after", tag), {62'd0, hm_busy, hm_valid}, 64'd0);
      check($sformatf("%s_after_data", tag), hm_data, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bad;

    vecs[0] = mk(64'h10, 12'h008, 4'd0, 1'b0, 9,
                 64'h1234_5678_8764_4329, 64'd0, 64'd0, 64'd0);
    vecs[1] = mk(64'h10, 12'hFF8, 4'd2, 1'b0, 9,
                 64'h1234_5678_8764_4CD9, 64'h1234_5678_8764_4321,
                 64'h1234_5678_8764_4329, 64'd0);
    vecs[2] = mk(64'h0000_0001_0000_0000, 12'h000, 4'd0, 1'b1, 16,
                 64'd0, 64'd0, 64'd0, 64'd0);
    vecs[3] = mk(64'h0000_0000_FFFF_FFFF, 12'h100, 4'd1, 1'b0, 9,
                 64'h1234_5987_789A_B221, 64'h1234_5987_789A_B229, 64'd0, 64'd0);
    vecs[4] = mk(64'hFFFF_FFFF_FFFF_FFFF, 12'h010, 4'd3, 1'b1, 16,
                 64'd0, 64'd0, 64'd0, 64'd0);
    vecs[5] = mk(64'h0, 12'hFF0, 4'd3, 1'b0, 9,
                 64'h1234_5678_8765_4CD1, 64'h1234_5678_8765_4CD9,
                 64'h1234_5678_8765_4321, 64'h1234_5678_8765_4329);

    sys_rst        = 1'b1;
    en             = 1'b1;
    hm_start       = 1'b0;
    hm_page_addr   = 64'd0;
    hm_page_offset = 12'd0;
    hm_len         = 4'd0;
`ifdef CHECKER_HM_ERRINJ_EN
    hm_inject      = 1'b0;
`endif
    step();
    step();
    check("reset_outputs", {60'd0, hm_valid, hm_end, hm_timeout, hm_busy}, 64'd0);
    check("reset_data", hm_data, 64'd0);
    sys_rst = 1'b0;
    step();
    check("idle_busy", {63'd0, hm_busy}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Stall in WAIT for 5 cycles, then in DATA for 2 cycles.
    accept(vecs[1]);
    repeat (3) step();
    en  = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (hm_valid || hm_end || hm_timeout || hm_busy !== 1'b1) bad++;
    end
    check("stall_wait_quiet", 64'(bad), 64'd0);
    en = 1'b1;
    cyc = 0;
    while (!hm_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("stall_total_latency", 64'(cyc + 8), 64'd14);
    check("stall_w0", hm_data, vecs[1].w0);
    en  = 1'b0;
    bad = 0;
    repeat (2) begin
      step();
      if (hm_valid || hm_end || hm_data !== 64'd0 || hm_busy !== 1'b1) bad++;
    end
    check("stall_data_quiet", 64'(bad), 64'd0);
    en = 1'b1;
    step();
    check("stall_w1", hm_data, vecs[1].w1);
    check("stall_w1_flags", {62'd0, hm_valid, hm_end}, 64'd2);
    step();
    check("stall_w2", hm_data, vecs[1].w2);
    check("stall_w2_flags", {62'd0, hm_valid, hm_end}, 64'd3);
    step();

    // Reset asserted asynchronously while word 2 of a 4-word burst is out.
    accept(vecs[5]);
    repeat (9) step();
    check("rst_w0_valid", {63'd0, hm_valid}, 64'd1);
    step();
    check("rst_w1_data", hm_data, vecs[5].w1);
    #2 sys_rst = 1'b1;
    #1;
    check("rst_async_flags", {60'd0, hm_valid, hm_end, hm_timeout, hm_busy}, 64'd0);
    check("rst_async_data", hm_data, 64'd0);
    step();
    sys_rst = 1'b0;
    bad = 0;
    repeat (20) begin
      step();
      if (hm_valid || hm_busy || hm_end || hm_timeout) bad++;
    end
    check("rst_no_resume", 64'(bad), 64'd0);
    run_vec(vecs[0], "post_rst");

    // Start held across the end pulse: ignored that cycle, accepted the next.
    accept(vecs[0]);
    repeat (9) step();
    check("b2b_end", {62'd0, hm_valid, hm_end}, 64'd3);
    hm_start = 1'b1;
    step();
    check("b2b_ignored", {63'd0, hm_busy}, 64'd0);
    step();
    check("b2b_accepted", {63'd0, hm_busy}, 64'd1);
    hm_start = 1'b0;
    repeat (8) step();
    check("b2b_not_yet", {63'd0, hm_valid}, 64'd0);
    step();
    check("b2b_valid", {62'd0, hm_valid, hm_end}, 64'd3);
    check("b2b_data", hm_data, vecs[0].w0);
    step();

`ifdef CHECKER_HM_ERRINJ_EN
    hm_inject = 1'b1;
    run_vec(mk(64'h10, 12'h008, 4'd0, 1'b1, 16, 64'd0, 64'd0, 64'd0, 64'd0), "inject1");
    hm_inject = 1'b0;
    run_vec(vecs[0], "inject0");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
